if_stage: RTL and testbench

Instruction fetch stage for the RISC-V datapath. It holds the PC, fetches instructions over a split request/response memory port, and drives the IF/ID register. The main control unit and the register file decode the `I` output of this block. Downstream stall and EX-stage branch redirect are handled inside the block: a skid buffer absorbs responses that arrive while ID is stalled, and a drain state discards responses from fetches on the wrong path.

---
 rtl/imem_if.sv | 37 +++
 rtl/if_stage.sv | 174 +++++++++++++++++
 tb/tb_if_stage.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/imem_if.sv
// ---------------------------------------------------------------------------
// imem_if : split request/response instruction-memory port.
//
//   imem_req    fetcher -> memory : address phase valid
//   imem_addr   fetcher -> memory : word-aligned fetch address
//   imem_gnt    memory  -> fetcher: request accepted when req & gnt at an edge
//   imem_rvalid memory  -> fetcher: response word valid (>=1 cycle after gnt)
//   imem_rdata  memory  -> fetcher: instruction word
//
// Handshake: the address phase completes on a rising edge where imem_req and
// imem_gnt are both 1. The data phase completes on any rising edge where
// imem_rvalid is 1; the fetcher never back-pressures a response, and at most
// one request is outstanding at a time.
// ---------------------------------------------------------------------------
interface imem_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage : RISC-V instruction fetch stage with IF/ID register.
//
// Holds the PC, fetches one word at a time over the imem_if port and presents
// it to decode on I / pc_out / valid. A one-word skid buffer (FULL state)
// catches a response that arrives while decode is stalled, and a DRAIN state
// throws away the response of a fetch made on the wrong path after a redirect.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   imem            imem_if.master fetch port
//   stall           decode cannot accept; IF/ID holds
//   branch_taken    redirect from EX (highest priority)
//   branch_target   redirect PC, low two bits ignored
//   I, pc_out       IF/ID instruction and its PC
//   valid           I holds a real instruction
//   dbg_state       current FSM state (REQ/WAIT/DRAIN/FULL)
//   dbg_pc          current fetch PC
// ---------------------------------------------------------------------------
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    imem_if.master      imem,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] I,
    output logic [31:0] pc_out,
    output logic        valid,
    output logic [1:0]  dbg_state,
    output logic [31:0] dbg_pc
);

    localparam logic [1:0] ST_REQ   = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_FULL  = 2'd3;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic        valid_q, valid_d;

    logic        free;
    logic        capture;
    logic [31:0] capture_word;
    logic [31:0] target_aligned;

    // Masking keeps the whole target bus in use while forcing word alignment.
    assign target_aligned = branch_target & ~32'h0000_0003;

    // IF/ID slot can take a word if it is empty or being consumed this cycle.
    assign free = ~valid_q | ~stall;

    // ------------------------------------------------------------------
    // Fetch FSM and PC
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        buf_d        = buf_q;
        capture      = 1'b0;
        capture_word = buf_q;

        unique case (state_q)
            ST_REQ: begin
                if (branch_taken) begin
                    pc_d = target_aligned;
                    // A grant in the same cycle launched a wrong-path fetch.
                    if (imem.imem_gnt) state_d = ST_DRAIN;
                end else if (imem.imem_gnt) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (branch_taken) begin
                    pc_d = target_aligned;
                    // Response in the same cycle is dropped on the floor;
                    // otherwise it is still coming and must be drained.
                    state_d = imem.imem_rvalid ? ST_REQ : ST_DRAIN;
                end else if (imem.imem_rvalid) begin
                    if (free) begin
                        capture      = 1'b1;
                        capture_word = imem.imem_rdata;
                        state_d      = ST_REQ;
                    end else begin
                        buf_d   = imem.imem_rdata;
                        state_d = ST_FULL;
                    end
                end
            end
            ST_DRAIN: begin
                if (branch_taken) pc_d = target_aligned;
                if (imem.imem_rvalid) state_d = ST_REQ;
            end
            ST_FULL: begin
                if (branch_taken) begin
                    pc_d    = target_aligned;
                    state_d = ST_REQ;
                end else if (!stall) begin
                    capture      = 1'b1;
                    capture_word = buf_q;
                    state_d      = ST_REQ;
                end
            end
            default: state_d = ST_REQ;
        endcase

        // The capture PC increment wraps naturally at 2^32.
        if (capture) pc_d = pc_q + 32'd4;
    end

    // ------------------------------------------------------------------
    // IF/ID register
    // ------------------------------------------------------------------
    always_comb begin
        instr_d  = instr_q;
        pc_out_d = pc_out_q;
        valid_d  = valid_q;

        if (capture) begin
            instr_d  = capture_word;
            pc_out_d = pc_q;
            valid_d  = 1'b1;
        end else if (branch_taken) begin
            // Flush wins over stall.
            instr_d = NOP;
            valid_d = 1'b0;
        end else if (stall && valid_q) begin
            instr_d = instr_q;
            valid_d = 1'b1;
        end else begin
            instr_d = NOP;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_REQ;
            pc_q     <= RESET_PC;
            buf_q    <= 32'h0;
            instr_q  <= NOP;
            pc_out_q <= RESET_PC;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            buf_q    <= buf_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
            valid_q  <= valid_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign imem.imem_req  = (state_q == ST_REQ) & ~rst;
    assign imem.imem_addr = pc_q;

    assign I         = instr_q;
    assign pc_out    = pc_out_q;
    assign valid     = valid_q;
    assign dbg_state = state_q;
    assign dbg_pc    = pc_q;

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage : directed bench for if_stage. The memory side is driven by
// hand each cycle; every expected value is a hand-computed constant.
// ---------------------------------------------------------------------------
module tb_if_stage;

    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] S_REQ    = 32'd0;
    localparam logic [31:0] S_WAIT   = 32'd1;
    localparam logic [31:0] S_DRAIN  = 32'd2;
    localparam logic [31:0] S_FULL   = 32'd3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    imem_if imem ();

    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] I;
    logic [31:0] pc_out;
    logic        valid;
    logic [1:0]  dbg_state;
    logic [31:0] dbg_pc;

    if_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem          (imem.master),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .I             (I),
        .pc_out        (pc_out),
        .valid         (valid),
        .dbg_state     (dbg_state),
        .dbg_pc        (dbg_pc)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Advance one edge; inputs change and outputs are sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic gnt, input logic rv, input logic [31:0] rd,
                         input logic stl, input logic br, input logic [31:0] tgt);
        imem.imem_gnt    = gnt;
        imem.imem_rvalid = rv;
        imem.imem_rdata  = rd;
        stall            = stl;
        branch_taken     = br;
        branch_target    = tgt;
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] ei,
                              input logic [31:0] epc, input logic ev);
        check_eq({tag, ".I"}, I, ei);
        check_eq({tag, ".pc_out"}, pc_out, epc);
        check_eq({tag, ".valid"}, {31'd0, valid}, {31'd0, ev});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        rst = 1'b1;
        step();
        step();

        // Reset state
        check_ifid("reset", NOP, 32'h0, 1'b0);
        check_eq("reset.state", {30'd0, dbg_state}, S_REQ);
        check_eq("reset.req_forced_low", {31'd0, imem.imem_req}, 32'd0);

        rst = 1'b0;
        #1;
        check_eq("first.req", {31'd0, imem.imem_req}, 32'd1);
        check_eq("first.addr", imem.imem_addr, 32'h0);

        // Straight-line fetch, zero-wait memory
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step();
        check_eq("sl.wait_state", {30'd0, dbg_state}, S_WAIT);
        check_eq("sl.wait_req", {31'd0, imem.imem_req}, 32'd0);
        drive(1'b0, 1'b1, 32'h0050_0093, 1'b0, 1'b0, 32'h0);
        step();
        check_ifid("sl.word0", 32'h0050_0093, 32'h0, 1'b1);
        check_eq("sl.addr4", imem.imem_addr, 32'h4);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step();
        check_ifid("sl.gap", NOP, 32'h0, 1'b0);
        drive(1'b0, 1'b1, 32'h00A0_0113, 1'b0, 1'b0, 32'h0);
        step();
        check_ifid("sl.word1", 32'h00A0_0113, 32'h4, 1'b1);
        check_eq("sl.addr8", imem.imem_addr, 32'h8);

        // Stall skid: response lands in the buffer while ID is stalled
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        step();
        check_ifid("skid.hold_wait", 32'h00A0_0113, 32'h4, 1'b1);
        drive(1'b0, 1'b1, 32'h0020_81B3, 1'b1, 1'b0, 32'h0);
        step();
        check_eq("skid.state_full", {30'd0, dbg_state}, S_FULL);
        check_eq("skid.req_low", {31'd0, imem.imem_req}, 32'd0);
        check_ifid("skid.hold_full", 32'h00A0_0113, 32'h4, 1'b1);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        step();
        check_eq("skid.still_full", {30'd0, dbg_state}, S_FULL);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step();
        check_ifid("skid.release", 32'h0020_81B3, 32'h8, 1'b1);
        check_eq("skid.pc_adv", dbg_pc, 32'hC);
        check_eq("skid.state_req", {30'd0, dbg_state}, S_REQ);

        // Redirect while WAIT, late response drained
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step();
        check_eq("rw.wait", {30'd0, dbg_state}, S_WAIT);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h40);
        step();
        check_eq("rw.drain", {30'd0, dbg_state}, S_DRAIN);
        check_ifid("rw.flush", NOP, 32'h8, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step();
        check_eq("rw.drain_hold", {30'd0, dbg_state}, S_DRAIN);
        drive(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
        step();
        check_ifid("rw.late_dropped", NOP, 32'h8, 1'b0);
        check_eq("rw.req", {31'd0, imem.imem_req}, 32'd1);
        check_eq("rw.addr", imem.imem_addr, 32'h40);

        // Redirect coincident with rvalid under stall
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step();
        drive(1'b0, 1'b1, 32'h1111_1113, 1'b0, 1'b0, 32'h0);
        step();
        check_ifid("co.word", 32'h1111_1113, 32'h40, 1'b1);
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        step();
        check_eq("co.wait", {30'd0, dbg_state}, S_WAIT);
        drive(1'b0, 1'b1, 32'h2222_2213, 1'b1, 1'b1, 32'h43);
        step();
        check_ifid("co.flush", NOP, 32'h40, 1'b0);
        check_eq("co.state", {30'd0, dbg_state}, S_REQ);
        check_eq("co.addr_aligned", imem.imem_addr, 32'h40);

        // Redirect from REQ without grant, then wrap at the top of memory
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        step();
        check_eq("wr.req_state", {30'd0, dbg_state}, S_REQ);
        check_eq("wr.addr", imem.imem_addr, 32'hFFFF_FFFC);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step();
        drive(1'b0, 1'b1, 32'h0010_0093, 1'b0, 1'b0, 32'h0);
        step();
        check_ifid("wr.word", 32'h0010_0093, 32'hFFFF_FFFC, 1'b1);
        check_eq("wr.pc_wrapped", dbg_pc, 32'h0);

        // Reset in WAIT, stray response afterwards
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step();
        check_eq("rs.wait", {30'd0, dbg_state}, S_WAIT);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        rst = 1'b1;
        step();
        check_ifid("rs.cleared", NOP, 32'h0, 1'b0);
        check_eq("rs.state", {30'd0, dbg_state}, S_REQ);
        check_eq("rs.req_low", {31'd0, imem.imem_req}, 32'd0);
        rst = 1'b0;
        drive(1'b0, 1'b1, 32'hBAD0_0013, 1'b0, 1'b0, 32'h0);
        #1;
        check_eq("rs.addr", imem.imem_addr, 32'h0);
        step();
        check_ifid("rs.stray_ignored", NOP, 32'h0, 1'b0);
        check_eq("rs.stray_state", {30'd0, dbg_state}, S_REQ);
        check_eq("rs.stray_req", {31'd0, imem.imem_req}, 32'd1);

        // ---------------- report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
